// File: rtl/add_arbiter.sv
// Two-requester 8-bit adder front end sharing a 4-bit multi-cycle adder.
// Optional watchdog: define ADD_ARB_TIMEOUT_EN to abort stalled nibble adds.
module add_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] sum,
    output logic       cout,
    output logic       busy,
    output logic       add_en,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    input  logic       add_ready,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        GAP  = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    logic       last;
    logic       gnt;
    logic       carry;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       pick;
    logic [7:0] pick_a;
    logic [7:0] pick_b;
    logic       timeout;

    // Tie goes to whoever was not served last; a lone requester always wins.
    assign pick   = (req0 & req1) ? ~last : req1;
    assign pick_a = pick ? a1 : a0;
    assign pick_b = pick ? b1 : b0;
    assign busy   = (state != IDLE);

`ifdef ADD_ARB_TIMEOUT_EN
    logic [4:0] wd;
    logic       waiting;

    assign waiting = (state == LO) || (state == HI);
    assign timeout = waiting && !add_ready && (wd == 5'd30);

    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            wd <= 5'd0;
        end else if (!add_ready) begin
            wd <= wd + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            gnt     <= 1'b0;
            carry   <= 1'b0;
            op_a    <= 8'd0;
            op_b    <= 8'd0;
            sum     <= 8'd0;
            cout    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            add_en  <= 1'b0;
            add_a   <= 4'd0;
            add_b   <= 4'd0;
            add_cin <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt     <= pick;
                        op_a    <= pick_a;
                        op_b    <= pick_b;
                        add_en  <= 1'b1;
                        add_a   <= pick_a[3:0];
                        add_b   <= pick_b[3:0];
                        add_cin <= 1'b0;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (add_ready) begin
                        sum[3:0] <= add_sum;
                        carry    <= add_cout;
                        add_en   <= 1'b0;
                        add_a    <= 4'd0;
                        add_b    <= 4'd0;
                        add_cin  <= 1'b0;
                        state    <= GAP;
                    end else if (timeout) begin
                        last    <= gnt;
                        add_en  <= 1'b0;
                        add_a   <= 4'd0;
                        add_b   <= 4'd0;
                        add_cin <= 1'b0;
                        state   <= IDLE;
                    end
                end
                GAP: begin
                    add_en  <= 1'b1;
                    add_a   <= op_a[7:4];
                    add_b   <= op_b[7:4];
                    add_cin <= carry;
                    state   <= HI;
                end
                HI: begin
                    if (add_ready) begin
                        sum[7:4] <= add_sum;
                        cout     <= add_cout;
                        add_en   <= 1'b0;
                        add_a    <= 4'd0;
                        add_b    <= 4'd0;
                        add_cin  <= 1'b0;
                        done0    <= ~gnt;
                        done1    <= gnt;
                        state    <= DONE;
                    end else if (timeout) begin
                        last    <= gnt;
                        add_en  <= 1'b0;
                        add_a   <= 4'd0;
                        add_b   <= 4'd0;
                        add_cin <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    last  <= gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a 3-cycle nibble adder model.
// Timeout scenario is exercised only when ADD_ARB_TIMEOUT_EN is defined.
module tb_add_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] a0 = 8'd0;
    logic [7:0] b0 = 8'd0;
    logic [7:0] a1 = 8'd0;
    logic [7:0] b1 = 8'd0;
    logic       done0;
    logic       done1;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       add_en;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic       add_ready;
    logic       err;

    logic       stall = 1'b0;
    logic [1:0] cnt = 2'd0;
    logic [4:0] full;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    add_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .sum(sum), .cout(cout),
        .busy(busy), .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .add_ready(add_ready), .err(err)
    );

    // Adder model: ready on the 3rd consecutive enabled cycle.
    always_ff @(posedge clk) begin
        if (!add_en) cnt <= 2'd0;
        else if (cnt < 2'd3) cnt <= cnt + 2'd1;
    end
    assign full      = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_sum   = full[3:0];
    assign add_cout  = full[4];
    assign add_ready = add_en && (cnt >= 2'd2) && !stall;

    task automatic watch(input int budget, output int which,
                         output int gap, output logic cin_hi);
        int phase;
        phase  = 0;
        which  = -1;
        gap    = 0;
        cin_hi = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            case (phase)
                0: if (add_en) phase = 1;
                1: if (!add_en) begin phase = 2; gap = 1; end
                2: if (!add_en) gap++;
                   else begin phase = 3; cin_hi = add_cin; end
                default: ;
            endcase
            if (done0 || done1) begin
                which = (done0 && done1) ? 2 : (done0 ? 0 : 1);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done0, done1, busy, err, add_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {done0, done1, busy, err, add_en});
        end
        checks++;
        if ({cout, sum} !== 9'h000) begin
            errors++;
            $display("FAIL reset_sum: got %h want 000", {cout, sum});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int w, g;
        logic c;
        a0 = 8'h3C; b0 = 8'h05; req0 = 1'b1;
        watch(40, w, g, c);
        req0 = 1'b0;
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL basic_done: got %0d want 0", w);
        end
        checks++;
        if ({cout, sum} !== 9'h041) begin
            errors++;
            $display("FAIL basic_sum: got %h want 041", {cout, sum});
        end
        checks++;
        if (g !== 1) begin
            errors++;
            $display("FAIL basic_gap: got %0d want 1", g);
        end
        @(negedge clk);
    endtask

    task automatic test_carry();
        int w, g;
        logic c;
        a1 = 8'hFF; b1 = 8'h01; req1 = 1'b1;
        watch(40, w, g, c);
        req1 = 1'b0;
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL carry_done: got %0d want 1", w);
        end
        checks++;
        if (c !== 1'b1) begin
            errors++;
            $display("FAIL carry_cin: got %b want 1", c);
        end
        checks++;
        if ({cout, sum} !== 9'h100) begin
            errors++;
            $display("FAIL carry_sum: got %h want 100", {cout, sum});
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int w, g;
        logic c;
        test_reset();
        a0 = 8'h12; b0 = 8'h34; a1 = 8'h80; b1 = 8'h80;
        req0 = 1'b1; req1 = 1'b1;
        watch(40, w, g, c);
        req0 = 1'b0;
        checks++;
        if (w !== 0 || {cout, sum} !== 9'h046) begin
            errors++;
            $display("FAIL rr_first: got %0d/%h want 0/046", w, {cout, sum});
        end
        watch(40, w, g, c);
        req1 = 1'b0;
        checks++;
        if (w !== 1 || {cout, sum} !== 9'h100) begin
            errors++;
            $display("FAIL rr_second: got %0d/%h want 1/100", w, {cout, sum});
        end
        @(negedge clk);
        a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
        watch(40, w, g, c);
        req0 = 1'b0;
        @(negedge clk);
        a0 = 8'h10; b0 = 8'h10; a1 = 8'h07; b1 = 8'h08;
        req0 = 1'b1; req1 = 1'b1;
        watch(40, w, g, c);
        req1 = 1'b0;
        checks++;
        if (w !== 1 || {cout, sum} !== 9'h00F) begin
            errors++;
            $display("FAIL rr_tie1: got %0d/%h want 1/00f", w, {cout, sum});
        end
        watch(40, w, g, c);
        req0 = 1'b0;
        checks++;
        if (w !== 0 || {cout, sum} !== 9'h020) begin
            errors++;
            $display("FAIL rr_tie0: got %0d/%h want 0/020", w, {cout, sum});
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int w, g;
        logic c;
        a0 = 8'h0F; b0 = 8'h01; req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a0 = 8'hAA; b0 = 8'h55; req0 = 1'b0;
        watch(40, w, g, c);
        checks++;
        if (w !== 0 || {cout, sum} !== 9'h010) begin
            errors++;
            $display("FAIL hold_op: got %0d/%h want 0/010", w, {cout, sum});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got busy=%b want 0", busy);
        end
    endtask

`ifdef ADD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n, got;
        logic seen, dn;
        logic [8:0] prev;
        prev = {cout, sum};
        stall = 1'b1;
        a0 = 8'h11; b0 = 8'h22; req0 = 1'b1;
        seen = 1'b0; dn = 1'b0; n = 0; got = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done0 || done1) dn = 1'b1;
            if (add_en && !seen) begin seen = 1'b1; n = 0; end
            else if (seen) n++;
            if (err) begin got = n; break; end
        end
        req0 = 1'b0;
        checks++;
        if (got !== 31) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d want 31", got);
        end
        checks++;
        if (dn !== 1'b0 || busy !== 1'b0 || {cout, sum} !== prev) begin
            errors++;
            $display("FAIL tmo_state: got dn=%b busy=%b sum=%h want 0/0/%h",
                     dn, busy, {cout, sum}, prev);
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: got err=%b want 0", err);
        end
    endtask
`else
    task automatic test_no_timeout();
        int w, g;
        logic c, saw_err;
        stall = 1'b1;
        a0 = 8'h21; b0 = 8'h43; req0 = 1'b1;
        saw_err = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (err) saw_err = 1'b1;
        end
        checks++;
        if (saw_err !== 1'b0 || busy !== 1'b1 || add_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait: got err=%b busy=%b en=%b want 0/1/1",
                     saw_err, busy, add_en);
        end
        stall = 1'b0;
        watch(40, w, g, c);
        req0 = 1'b0;
        checks++;
        if (w !== 0 || {cout, sum} !== 9'h064) begin
            errors++;
            $display("FAIL stall_done: got %0d/%h want 0/064", w, {cout, sum});
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int phase;
        logic dn;
        a1 = 8'h22; b1 = 8'h33; req1 = 1'b1;
        phase = 0;
        for (int i = 0; i < 20 && phase < 3; i++) begin
            @(negedge clk);
            case (phase)
                0: if (add_en) phase = 1;
                1: if (!add_en) phase = 2;
                default: if (add_en) phase = 3;
            endcase
        end
        checks++;
        if (phase !== 3) begin
            errors++;
            $display("FAIL rmid_reach: got phase %0d want 3", phase);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, add_en, done0, done1} !== 4'b0 || {cout, sum} !== 9'h0) begin
            errors++;
            $display("FAIL rmid_state: got %b sum=%h want 0000 sum=000",
                     {busy, add_en, done0, done1}, {cout, sum});
        end
        rst = 1'b0; req1 = 1'b0;
        dn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0 || done1) dn = 1'b1;
        end
        checks++;
        if (dn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nodone: got done=%b busy=%b want 0/0", dn, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_hold();
`ifdef ADD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have ports req0/req1, input, 1 each, level request from requester 0/1, held until matching done.
REQ-004 SHALL have ports a0/b0 and a1/b1, input, 8 each, 8-bit operands of requester 0/1.
REQ-005 SHALL have ports done0/done1, output, 1 each, one-cycle pulse: result valid for requester 0/1.
REQ-006 SHALL have port sum, output, 8, registered 8-bit result, held until next done.
REQ-007 SHALL have port cout, output, 1, registered carry out of bit 7, held with sum.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have ports add_en (out, 1), add_a (out, 4), add_b (out, 4), add_cin (out, 1): drive the shared 4-bit adder.
REQ-010 SHALL have ports add_sum (in, 4), add_cout (in, 1), add_ready (in, 1): adder result, carry, completion flag.
REQ-011 SHALL have port err, output, 1, timeout abort pulse (REQ-027).

Function
REQ-012 SHALL implement FSM states IDLE, LO, GAP, HI, DONE.
REQ-013 IDLE: if any req high, SHALL grant one requester, capture its a/b into internal 8-bit registers, go to LO next cycle.
REQ-014 Arbitration SHALL be round-robin: both requesting -> grant requester not served last; single requester -> grant it.
REQ-015 LO: add_en=1, add_a/add_b = captured operand bits [3:0], add_cin=0; on add_ready=1 SHALL latch add_sum into sum[3:0] and add_cout into internal carry, go to GAP.
REQ-016 GAP: add_en=0 for exactly one cycle (restarts adder internal count), then go to HI.
REQ-017 HI: add_en=1, add_a/add_b = operand bits [7:4], add_cin = latched low carry; on add_ready=1 SHALL latch add_sum into sum[7:4] and add_cout into cout, go to DONE.
REQ-018 DONE: add_en=0, pulse done of granted requester for one cycle, update last-served pointer, return to IDLE.
REQ-019 add_en SHALL be 0 in IDLE, GAP, DONE; add_a/add_b/add_cin SHALL be 0 whenever add_en=0.
REQ-020 add_sum/add_cout SHALL be sampled only in the cycle add_ready=1 while in LO/HI; add_ready elsewhere SHALL be ignored.
REQ-021 sum/cout SHALL update only at LO/HI capture; arithmetic is unsigned modulo 256, cout = bit 8.
REQ-022 Deasserting the granted req mid-operation SHALL NOT abort; operation completes and done still pulses.
REQ-023 Operand changes after grant SHALL NOT affect the in-flight operation.
REQ-024 Request arriving in DONE SHALL be served from the following IDLE cycle; minimum one IDLE cycle between operations.

Reset
REQ-025 rst=1 SHALL force state IDLE, last-served pointer = requester 1 (requester 0 wins first tie), sum=0, cout=0, done0=done1=0, busy=0, err=0, add_en=0.
REQ-026 rst mid-operation SHALL abort without done pulse; adder returns to idle via add_en=0.

Configuration
REQ-027 Macro ADD_ARB_TIMEOUT_EN defined: 5-bit watchdog counts cycles in LO/HI, cleared on entry to each; at 31 cycles without add_ready, SHALL pulse err one cycle, skip done, leave sum/cout unchanged, update pointer, return to IDLE.
REQ-028 Macro ADD_ARB_TIMEOUT_EN undefined: no watchdog, LO/HI wait indefinitely, err tied 0.

Verification (adder model: ready on 3rd consecutive en cycle)
REQ-029 req0 only, a0=0x3C, b0=0x05 -> done0 pulse, sum=0x41, cout=0; add_en low exactly one cycle between nibbles.
REQ-030 req1 only, a1=0xFF, b1=0x01 -> low nibble carry propagates, add_cin=1 in HI, sum=0x00, cout=1, done1.
REQ-031 req0 and req1 high same cycle after reset -> requester 0 served first, then requester 1; neither done overlaps; no done1 before done0.
REQ-032 rst asserted during HI -> next cycle IDLE, busy=0, add_en=0, no done pulse, sum=0.
REQ-033 With ADD_ARB_TIMEOUT_EN, adder model never asserts ready -> err pulse 31 cycles after LO entry, no done, state IDLE.
